dm_responder: RTL

//  Data-memory responder for the multi-cycle CPU. It serves load/store requests from the core over a req/ready handshake.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_lane_unit.sv | 42 ++++
 rtl/dm_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-width encodings
// (also used by the core's control unit) and responder FSM states.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_HU = 3'b001,
        DM_H  = 3'b010,
        DM_BU = 3'b011,
        DM_B  = 3'b100
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } dm_state_e;

    function automatic logic ctrl_valid(input logic [2:0] ctrl);
        return ctrl <= DM_B;
    endfunction

    function automatic logic ctrl_is_half(input logic [2:0] ctrl);
        return (ctrl == DM_HU) || (ctrl == DM_H);
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: extracts and extends a load result from a memory
// word, and merges right-aligned store data into the addressed lane.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  ctrl,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rd_word >> {offset, 3'b000};
        load_data = '0;
        case (ctrl)
            DM_W:    load_data = rd_word;
            DM_HU:   load_data = {16'h0000, shifted[15:0]};
            DM_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            DM_BU:   load_data = {24'h000000, shifted[7:0]};
            DM_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = rd_word;
        case (ctrl)
            DM_W: merged_word = wdata;
            DM_HU, DM_H: begin
                if (offset[1]) merged_word[31:16] = wdata[15:0];
                else           merged_word[15:0]  = wdata[15:0];
            end
            DM_BU, DM_B: merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
            default: merged_word = rd_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: captures a load/store request, spends
// WAIT_CYCLES wait states, performs the access, and pulses ready for one cycle.
module dm_responder
    import dm_pkg::*;
#(
    parameter int WORD_AW     = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ctrl,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 2 ** WORD_AW;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dm_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];
    logic [WORD_AW-1:0] word_idx;
    logic [31:0]        old_word, load_data, merged_word;
    logic               fault, mem_we;

    assign word_idx = addr_q[WORD_AW+1:2];
    assign old_word = mem[word_idx];

    always_comb begin
        fault = 1'b0;
        if (!ctrl_valid(ctrl_q))                        fault = 1'b1;
        if ((addr_q >> (WORD_AW + 2)) != '0)            fault = 1'b1;
        if (ctrl_is_half(ctrl_q) && addr_q[0])          fault = 1'b1;
        if ((ctrl_q == DM_W) && (addr_q[1:0] != 2'b00)) fault = 1'b1;
    end

    dm_lane_unit u_lane (
        .rd_word     (old_word),
        .wdata       (wdata_q),
        .offset      (addr_q[1:0]),
        .ctrl        (ctrl_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State is cleared asynchronously, so a reset in ACCESS also kills the write.
    assign mem_we = (state_q == S_ACCESS) && we_q && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    ctrl_d  = ctrl;
                    cnt_d   = '0;
                    if (WAIT_CYCLES == 0) state_d = S_ACCESS;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = S_ACCESS;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_ACCESS: begin
                rdata_d = (fault || we_q) ? '0 : load_data;
                err_d   = fault;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= merged_word;
    end

    assign rdata = rdata_q;
    assign err   = err_q;
    assign ready = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);

endmodule
